// File: rtl/rv32_pkg.sv
// RV32I decode types: opcode classes, immediate formats and the base opcode map.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE
    } immType_e;

    typedef enum logic [3:0] {
        INVALID,
        OP,
        OP_IMM,
        LOAD,
        STORE,
        BRANCH,
        JAL,
        JALR,
        LUI,
        AUIPC,
        SYSTEM
    } opcodeType_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/inst_decode_stage_decoder.sv
// Combinational field extraction and opcode classification for one RV32I instruction.
module inst_decode_stage_decoder
    import rv32_pkg::*;
(
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output opcodeType_e opcode_type,
    output immType_e    imm_type,
    output logic        rd_we,
    output logic        illegal
);

    logic writes_rd;
    logic bad_opcode;
    // funct3/funct7 are consumed by execute, not here
    logic unused_funct;

    assign unused_funct = ^{inst[31:25], inst[14:12]};

    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign rd  = inst[11:7];

    always_comb begin
        opcode_type = INVALID;
        imm_type    = R_TYPE;
        writes_rd   = 1'b0;
        bad_opcode  = 1'b0;
        case (inst[6:0])
            OPC_OP:     begin opcode_type = OP;     imm_type = R_TYPE; writes_rd = 1'b1; end
            OPC_OP_IMM: begin opcode_type = OP_IMM; imm_type = I_TYPE; writes_rd = 1'b1; end
            OPC_LOAD:   begin opcode_type = LOAD;   imm_type = I_TYPE; writes_rd = 1'b1; end
            OPC_JALR:   begin opcode_type = JALR;   imm_type = I_TYPE; writes_rd = 1'b1; end
            OPC_SYSTEM: begin opcode_type = SYSTEM; imm_type = I_TYPE; end
            OPC_STORE:  begin opcode_type = STORE;  imm_type = S_TYPE; end
            OPC_BRANCH: begin opcode_type = BRANCH; imm_type = B_TYPE; end
            OPC_LUI:    begin opcode_type = LUI;    imm_type = U_TYPE; writes_rd = 1'b1; end
            OPC_AUIPC:  begin opcode_type = AUIPC;  imm_type = U_TYPE; writes_rd = 1'b1; end
            OPC_JAL:    begin opcode_type = JAL;    imm_type = J_TYPE; writes_rd = 1'b1; end
            default:    bad_opcode = 1'b1;
        endcase
    end

    // Side-effect flags only mean something for a real instruction
    assign rd_we   = inst_valid & writes_rd & (rd != 5'd0);
    assign illegal = inst_valid & bad_opcode;

endmodule

// File: rtl/inst_decode_stage_imm_gen.sv
// Sign-extended immediate assembly for the RV32I immediate formats.
module inst_decode_stage_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] inst,
    input  immType_e    imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (imm_type)
            I_TYPE:  imm = {{20{inst[31]}}, inst[31:20]};
            S_TYPE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            B_TYPE:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            U_TYPE:  imm = {inst[31:12], 12'd0};
            J_TYPE:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/inst_decode_stage.sv
// ID stage: combinational decode feeding the ID/EX pipeline register (flush > stall > load).
module inst_decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [31:0]     inst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output opcodeType_e     opcode_type_o,
    output immType_e        imm_type_o,
    output logic [XLEN-1:0] imm_o,
    output logic            rd_we_o,
    output logic            illegal_o
);

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    opcodeType_e opcode_type;
    immType_e    imm_type;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;

    inst_decode_stage_decoder u_decoder (
        .inst_valid  (inst_valid_i),
        .inst        (inst_i),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .opcode_type (opcode_type),
        .imm_type    (imm_type),
        .rd_we       (rd_we),
        .illegal     (illegal)
    );

    inst_decode_stage_imm_gen u_imm_gen (
        .inst     (inst_i[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o       <= 1'b0;
            rs1_o         <= 5'd0;
            rs2_o         <= 5'd0;
            rd_o          <= 5'd0;
            opcode_type_o <= INVALID;
            imm_type_o    <= R_TYPE;
            imm_o         <= '0;
            rd_we_o       <= 1'b0;
            illegal_o     <= 1'b0;
        end else if (flush_i) begin
            valid_o       <= 1'b0;
            rs1_o         <= 5'd0;
            rs2_o         <= 5'd0;
            rd_o          <= 5'd0;
            opcode_type_o <= INVALID;
            imm_type_o    <= R_TYPE;
            imm_o         <= '0;
            rd_we_o       <= 1'b0;
            illegal_o     <= 1'b0;
        end else if (!stall_i) begin
            valid_o       <= inst_valid_i;
            rs1_o         <= rs1;
            rs2_o         <= rs2;
            rd_o          <= rd;
            opcode_type_o <= opcode_type;
            imm_type_o    <= imm_type;
            imm_o         <= imm;
            rd_we_o       <= rd_we;
            illegal_o     <= illegal;
        end
    end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench for inst_decode_stage: decode vectors, invalid gating, stall/flush, async reset.
module tb_inst_decode_stage;
    import rv32_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        opcodeType_e op;
        immType_e    it;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    opcodeType_e opcode_type_o;
    immType_e    imm_type_o;
    logic [31:0] imm_o;
    logic        rd_we_o;
    logic        illegal_o;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    out_t got;
    out_t want;
    out_t rst_out;

    always #5 clk = ~clk;

    inst_decode_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_valid_i  (inst_valid_i),
        .inst_i        (inst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .rd_o          (rd_o),
        .opcode_type_o (opcode_type_o),
        .imm_type_o    (imm_type_o),
        .imm_o         (imm_o),
        .rd_we_o       (rd_we_o),
        .illegal_o     (illegal_o)
    );

    function automatic out_t mk(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                                opcodeType_e op, immType_e it, logic [31:0] imm,
                                logic we, logic ill);
        out_t o;
        o.valid = v; o.rs1 = r1; o.rs2 = r2; o.rd = d; o.op = op; o.it = it;
        o.imm = imm; o.rd_we = we; o.illegal = ill;
        return o;
    endfunction

    function automatic out_t sample();
        return mk(valid_o, rs1_o, rs2_o, rd_o, opcode_type_o, imm_type_o, imm_o, rd_we_o,
                  illegal_o);
    endfunction

    task automatic test_reset();
        rst_out = mk(1'b0, 5'd0, 5'd0, 5'd0, INVALID, R_TYPE, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0; inst_valid_i = 1'b0; inst_i = 32'd0; stall_i = 1'b0; flush_i = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== rst_out) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", got, rst_out);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got = sample();
        checks++;
        if (got !== rst_out) begin
            errors++;
            $display("FAIL reset_release got %h want %h", got, rst_out);
        end
    endtask

    // Streams instructions back to back; each result is checked one cycle later.
    task automatic test_decode();
        logic [31:0] vin[7];
        out_t        vexp[7];
        vin[0] = 32'hfff48413;
        vexp[0] = mk(1, 5'd9, 5'd31, 5'd8, OP_IMM, I_TYPE, 32'hffffffff, 1, 0);
        vin[1] = 32'h4c84a923;
        vexp[1] = mk(1, 5'd9, 5'd8, 5'd18, STORE, S_TYPE, 32'd1234, 0, 0);
        vin[2] = 32'h06940d63;
        vexp[2] = mk(1, 5'd8, 5'd9, 5'd26, BRANCH, B_TYPE, 32'd122, 0, 0);
        vin[3] = 32'h10000437;
        vexp[3] = mk(1, 5'd0, 5'd0, 5'd8, LUI, U_TYPE, 32'h10000000, 1, 0);
        vin[4] = 32'h000100ef;
        vexp[4] = mk(1, 5'd2, 5'd0, 5'd1, JAL, J_TYPE, 32'd65536, 1, 0);
        vin[5] = 32'h0000007f;
        vexp[5] = mk(1, 5'd0, 5'd0, 5'd0, INVALID, R_TYPE, 32'd0, 0, 1);
        vin[6] = 32'h00000013;
        vexp[6] = mk(1, 5'd0, 5'd0, 5'd0, OP_IMM, I_TYPE, 32'd0, 0, 0);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got  = sample();
                want = sb.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL decode[%0d] got %h want %h", i - 1, got, want);
                end
            end
            if (i < 7) begin
                inst_valid_i = 1'b1;
                inst_i       = vin[i];
                sb.push_back(vexp[i]);
            end else begin
                inst_valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_invalid_gating();
        logic [31:0] vin[3];
        out_t        vexp[3];
        vin[0] = 32'h0000007f;
        vexp[0] = mk(0, 5'd0, 5'd0, 5'd0, INVALID, R_TYPE, 32'd0, 0, 0);
        vin[1] = 32'hfff48413;
        vexp[1] = mk(0, 5'd9, 5'd31, 5'd8, OP_IMM, I_TYPE, 32'hffffffff, 0, 0);
        vin[2] = 32'h00001517;
        vexp[2] = mk(1, 5'd0, 5'd0, 5'd10, AUIPC, U_TYPE, 32'h00001000, 1, 0);
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got  = sample();
                want = sb.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL gating[%0d] got %h want %h", i - 1, got, want);
                end
            end
            if (i < 3) begin
                inst_valid_i = (i == 2);
                inst_i       = vin[i];
                sb.push_back(vexp[i]);
            end else begin
                inst_valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_stall_flush();
        out_t addi;
        addi = mk(1, 5'd9, 5'd31, 5'd8, OP_IMM, I_TYPE, 32'hffffffff, 1, 0);
        @(negedge clk);
        inst_valid_i = 1'b1; inst_i = 32'hfff48413;
        sb.push_back(addi);
        @(negedge clk);
        // New instruction presented while stalled must not be captured
        stall_i = 1'b1; inst_i = 32'h4c84a923;
        sb.push_back(addi);
        sb.push_back(addi);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall_hold[%0d] got %h want %h", i, got, want);
            end
        end
        flush_i = 1'b1;
        @(negedge clk);
        got = sample();
        checks++;
        if (got !== rst_out) begin
            errors++;
            $display("FAIL flush_with_stall got %h want %h", got, rst_out);
        end
        flush_i = 1'b0; stall_i = 1'b0; inst_valid_i = 1'b0;
    endtask

    task automatic test_async_reset();
        out_t lui;
        lui = mk(1, 5'd0, 5'd0, 5'd8, LUI, U_TYPE, 32'h10000000, 1, 0);
        @(negedge clk);
        inst_valid_i = 1'b1; inst_i = 32'h10000437;
        @(negedge clk);
        stall_i = 1'b1;
        got = sample();
        checks++;
        if (got !== lui) begin
            errors++;
            $display("FAIL pre_reset_load got %h want %h", got, lui);
        end
        #2 rst_n = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== rst_out) begin
            errors++;
            $display("FAIL async_reset got %h want %h", got, rst_out);
        end
        @(negedge clk);
        got = sample();
        checks++;
        if (got !== rst_out) begin
            errors++;
            $display("FAIL reset_over_stall got %h want %h", got, rst_out);
        end
        rst_n = 1'b1; stall_i = 1'b0; inst_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_invalid_gating();
        test_stall_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- RV32I instruction-decode stage: splits a 32-bit instruction into register indices, an opcode class, an immediate format and a sign-extended immediate.
- A combinational decoder and immediate generator feed a one-entry output register (the ID pipeline register).
- Sits between instruction fetch and execute in the RV32 core.

Parameters:
- XLEN, 32, datapath/immediate width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid_i  in  1  inst_i holds a valid instruction this cycle.
- inst_i  in  32  raw instruction word.
- stall_i  in  1  hold the output register.
- flush_i  in  1  kill the output register contents.
- valid_o  out  1  registered outputs hold a decoded instruction.
- rs1_o  out  5  inst[19:15].
- rs2_o  out  5  inst[24:20].
- rd_o  out  5  inst[11:7].
- opcode_type_o  out  opcodeType_e  opcode class.
- imm_type_o  out  immType_e  immediate format.
- imm_o  out  32  sign-extended immediate (signed).
- rd_we_o  out  1  instruction writes rd, and rd != 0.
- illegal_o  out  1  unrecognised opcode.

Behaviour:
- Register fields are always extracted raw, regardless of format.
- Opcode map, inst[6:0] -> opcode_type / imm_type:
  - 0110011 -> OP / R_TYPE
  - 0010011 -> OP_IMM / I_TYPE
  - 0000011 -> LOAD / I_TYPE
  - 1100111 -> JALR / I_TYPE
  - 1110011 -> SYSTEM / I_TYPE
  - 0100011 -> STORE / S_TYPE
  - 1100011 -> BRANCH / B_TYPE
  - 0110111 -> LUI / U_TYPE
  - 0010111 -> AUIPC / U_TYPE
  - 1101111 -> JAL / J_TYPE
  - any other value -> INVALID / R_TYPE, illegal=1
- Immediates (sign bit is always inst[31]):
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U: {inst[31:12], 12'b0}
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - R_TYPE: 0
- rd_we = 1 for OP, OP_IMM, LOAD, JALR, LUI, AUIPC, JAL when rd != 0; otherwise 0 (always 0 for STORE, BRANCH, SYSTEM, INVALID).
- Latency: one cycle from inst_i to outputs. The register captures on every rising edge unless stalled.
- Update priority: flush_i > stall_i > load.
  - Flush: valid_o <= 0; all other outputs are cleared to their reset values.
  - Stall: all outputs hold.
  - Load: valid_o <= inst_valid_i; fields <= decoded values.
- When inst_valid_i=0, the fields are still loaded, but illegal_o and rd_we_o are forced to 0.
- Reset (asynchronous assert, synchronous release) clears:
  - valid_o, rs1_o, rs2_o, rd_o, imm_o, rd_we_o, illegal_o = 0
  - opcode_type_o = INVALID, imm_type_o = R_TYPE
- Flush and stall asserted together: flush wins.
- Reset asserted mid-stall: reset values win immediately.

Decomposition:
- Package rv32_pkg contains:
  - immType_e {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE}
  - opcodeType_e {INVALID, OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM}; INVALID encodes as 0.
  - the 7-bit opcode constants.
- Sub-modules:
  - decoder: combinational field extraction, opcode and immediate classification, rd_we, illegal.
  - imm_gen: inst + imm_type -> imm.
- The top level contains only the pipeline register.

Test Plan:
- inst 0xfff48413 (addi x8,x9,-1) -> next cycle: OP_IMM, I_TYPE, rd=8, rs1=9, imm=-1, rd_we=1.
- inst 0x4c84a923 (sw x8,1234(x9)) -> STORE, S_TYPE, rs1=9, rs2=8, imm=1234, rd_we=0.
- inst 0x06940d63 (beq x8,x9,122) -> BRANCH, B_TYPE, rs1=8, rs2=9, imm=122.
- inst 0x10000437 (lui x8) -> LUI, U_TYPE, rd=8, imm=0x10000000. Then inst 0x000100ef (jal x1) -> JAL, J_TYPE, rd=1, imm=65536.
- inst 0x0000007f -> INVALID, illegal_o=1, imm=0. Then inst 0x00000013 (addi x0) -> rd_we_o=0.
- Control sequence:
  - Load addi, then stall 2 cycles with new inst -> outputs hold addi.
  - Assert flush with stall -> valid_o=0, opcode INVALID.
  - Drop rst_n mid-stream -> all outputs go to reset values without a clock edge.
